ci_bus_arbiter: RTL and testbench

Two-requester arbiter and cycle sequencer for the 8-bit CI (PCMCIA-style) control bus. It shares the bus between the CAM configuration engine (port 0) and the CAM status poller (port 1). Each granted access runs as one parameterised setup/strobe/hold cycle that drives address, chip-enable, REG# and the OE/WE or IORD/IOWR strobes. It returns read data with an error flag and sits between the CI interface's control logic and the CI pins.

---
 rtl/ci_bus_pkg.sv | 40 ++++
 rtl/ci_rr_arbiter.sv | 30 +++
 rtl/ci_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ci_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ci_bus_pkg.sv
// Shared definitions for the CI control-bus arbiter: space codes, sequencer
// states, request record and the idle (parked) bus values.
package ci_bus_pkg;

    localparam logic [1:0] SPACE_ATTR   = 2'd0;
    localparam logic [1:0] SPACE_COMMON = 2'd1;
    localparam logic [1:0] SPACE_IO     = 2'd2;
    localparam logic [1:0] SPACE_RSVD   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } bus_state_t;

    // Parked bus values; the CI interface uses the same set when no card is present.
    localparam logic [7:0] IDLE_A      = 8'h00;
    localparam logic [6:0] IDLE_A_EXT  = 7'h00;
    localparam logic [7:0] IDLE_D      = 8'h00;
    localparam logic       IDLE_D_OE   = 1'b0;
    localparam logic       IDLE_CTL_N  = 1'b1;
    localparam logic       IDLE_BUS_OE = 1'b0;

    typedef struct packed {
        logic        id;
        logic [1:0]  space;
        logic        write;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } ci_req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ci_rr_arbiter.sv
// Two-way round-robin grant; the last-granted port loses the next tie.
module ci_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1])
                gnt = last ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end

endmodule

// File: rtl/ci_bus_arbiter.sv
// Shares the CI control bus between two requesters and runs each granted
// access as a setup/strobe/hold cycle with a one-cycle response pulse.
module ci_bus_arbiter
    import ci_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 10,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_space,
    input  logic        req0_write,
    input  logic [14:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_space,
    input  logic        req1_write,
    input  logic [14:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        cam_present,
    output logic [7:0]  ci_a,
    output logic [6:0]  ci_a_ext,
    input  logic [7:0]  ci_d_in,
    output logic [7:0]  ci_d_out,
    output logic        ci_d_oe,
    output logic        ci_reg_n,
    output logic        ci_ce1_n,
    output logic        ci_oe_n,
    output logic        ci_we_n,
    output logic        ci_iord_n,
    output logic        ci_iowr_n,
    input  logic        ci_inpack_n,
    output logic        bus_oe,
    output logic        busy
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

    bus_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    ci_req_t          sel;
    logic             own_id, own_io, own_write;
    logic [7:0]       samp_d;
    logic             samp_inpack_n;

    ci_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .en  ((state == ST_IDLE) && !rst),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign busy       = (state != ST_IDLE);

    always_comb begin
        if (gnt[1])
            sel = '{id: 1'b1, space: req1_space, write: req1_write, addr: req1_addr, wdata: req1_wdata};
        else
            sel = '{id: 1'b0, space: req0_space, write: req0_write, addr: req0_addr, wdata: req0_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            own_id        <= 1'b0;
            own_io        <= 1'b0;
            own_write     <= 1'b0;
            samp_d        <= '0;
            samp_inpack_n <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            ci_a          <= IDLE_A;
            ci_a_ext      <= IDLE_A_EXT;
            ci_d_out      <= IDLE_D;
            ci_d_oe       <= IDLE_D_OE;
            ci_reg_n      <= IDLE_CTL_N;
            ci_ce1_n      <= IDLE_CTL_N;
            ci_oe_n       <= IDLE_CTL_N;
            ci_we_n       <= IDLE_CTL_N;
            ci_iord_n     <= IDLE_CTL_N;
            ci_iowr_n     <= IDLE_CTL_N;
            bus_oe        <= IDLE_BUS_OE;
        end else begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        own_id    <= sel.id;
                        own_io    <= (sel.space == SPACE_IO);
                        own_write <= sel.write;
                        // Rejected requests answer immediately and never touch the pins.
                        if (sel.space == SPACE_RSVD || !cam_present) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_id    <= sel.id;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= ST_SETUP;
                            cnt      <= CNT_W'(SETUP_CYC - 1);
                            ci_a     <= sel.addr[7:0];
                            ci_a_ext <= sel.addr[14:8];
                            ci_ce1_n <= 1'b0;
                            ci_reg_n <= (sel.space == SPACE_COMMON);
                            bus_oe   <= 1'b1;
                            if (sel.write) begin
                                ci_d_out <= sel.wdata;
                                ci_d_oe  <= 1'b1;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_STROBE;
                        cnt   <= CNT_W'(STROBE_CYC - 1);
                        if (own_io) begin
                            ci_iowr_n <= !own_write;
                            ci_iord_n <= own_write;
                        end else begin
                            ci_we_n <= !own_write;
                            ci_oe_n <= own_write;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        state         <= ST_HOLD;
                        cnt           <= CNT_W'(HOLD_CYC - 1);
                        ci_oe_n       <= IDLE_CTL_N;
                        ci_we_n       <= IDLE_CTL_N;
                        ci_iord_n     <= IDLE_CTL_N;
                        ci_iowr_n     <= IDLE_CTL_N;
                        samp_d        <= ci_d_in;
                        samp_inpack_n <= ci_inpack_n;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state     <= ST_RESP;
                        ci_a      <= IDLE_A;
                        ci_a_ext  <= IDLE_A_EXT;
                        ci_d_out  <= IDLE_D;
                        ci_d_oe   <= IDLE_D_OE;
                        ci_reg_n  <= IDLE_CTL_N;
                        ci_ce1_n  <= IDLE_CTL_N;
                        bus_oe    <= IDLE_BUS_OE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= own_id;
                        if (own_io && !own_write && samp_inpack_n)
                            rsp_err <= 1'b1;
                        else if (!own_write)
                            rsp_rdata <= samp_d;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ci_bus_arbiter.sv
// Scenario bench for ci_bus_arbiter: expected responses are queued at issue
// time and popped by a monitor on each rsp_valid pulse.
module tb_ci_bus_arbiter;
    import ci_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_write;
    logic [1:0]  req0_space;
    logic [14:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [1:0]  req1_space;
    logic [14:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        cam_present;
    logic [7:0]  ci_a, ci_d_in, ci_d_out;
    logic [6:0]  ci_a_ext;
    logic        ci_d_oe, ci_reg_n, ci_ce1_n, ci_oe_n, ci_we_n, ci_iord_n, ci_iowr_n;
    logic        ci_inpack_n, bus_oe, busy;

    ci_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_space(req0_space),
        .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_space(req1_space),
        .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cam_present(cam_present),
        .ci_a(ci_a), .ci_a_ext(ci_a_ext), .ci_d_in(ci_d_in), .ci_d_out(ci_d_out), .ci_d_oe(ci_d_oe),
        .ci_reg_n(ci_reg_n), .ci_ce1_n(ci_ce1_n), .ci_oe_n(ci_oe_n), .ci_we_n(ci_we_n),
        .ci_iord_n(ci_iord_n), .ci_iowr_n(ci_iowr_n), .ci_inpack_n(ci_inpack_n),
        .bus_oe(bus_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; logic [7:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    localparam logic [30:0] BUS_IDLE = {8'h00, 7'h00, 8'h00, 1'b0, 6'b111111, 1'b0};
    logic [30:0] bus_vec;
    assign bus_vec = {ci_a, ci_a_ext, ci_d_out, ci_d_oe, ci_reg_n, ci_ce1_n,
                      ci_oe_n, ci_we_n, ci_iord_n, ci_iowr_n, bus_oe};

    logic [14:0] addr_prev = '0;
    logic        oe_prev   = 1'b0;

    // Scoreboard pop plus bus-rule tally (one strobe max, no address/oe change under strobe).
    always @(negedge clk) begin
        int nlow;
        exp_t e;
        if (rsp_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got id=%0d rdata=%02h err=%0d, required no response",
                         rsp_id, rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
                    fails++;
                    $display("FAIL rsp_data: got id=%0d rdata=%02h err=%0d, required id=%0d rdata=%02h err=%0d",
                             rsp_id, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
                end
            end
        end
        nlow = int'(!ci_oe_n) + int'(!ci_we_n) + int'(!ci_iord_n) + int'(!ci_iowr_n);
        if (nlow > 1) viol++;
        if (nlow > 0 && ({ci_a_ext, ci_a} !== addr_prev || ci_d_oe !== oe_prev)) viol++;
        addr_prev = {ci_a_ext, ci_a};
        oe_prev   = ci_d_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %0d, required 0", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus_vec, busy, rsp_valid, rsp_id, rsp_rdata, rsp_err, req0_ready, req1_ready} !==
            {BUS_IDLE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got bus=%08h busy=%0d rsp_valid=%0d, required bus=%08h busy=0 rsp_valid=0",
                     bus_vec, busy, rsp_valid, BUS_IDLE);
        end
    endtask

    task automatic test_attr_read();
        int first_oe = -1, last_oe = -1, n_oe = 0, rsp_c = -1;
        logic rdy0, reg_c1, busy_c1, busy_c16;
        logic [14:0] a_c1;
        @(posedge clk); #1;
        cam_present = 1'b1;
        ci_d_in     = 8'hA5;
        req0_valid = 1'b1; req0_space = SPACE_ATTR; req0_write = 1'b0; req0_addr = 15'h0100;
        sb.push_back('{1'b0, 8'hA5, 1'b0});
        for (int c = 0; c < 20; c++) begin
            if (c == 1) req0_valid = 1'b0;
            @(negedge clk);
            if (c == 0) rdy0 = req0_ready;
            if (c == 1) begin reg_c1 = ci_reg_n; a_c1 = {ci_a_ext, ci_a}; busy_c1 = busy; end
            if (c == 16) busy_c16 = busy;
            if (!ci_oe_n) begin if (first_oe < 0) first_oe = c; last_oe = c; n_oe++; end
            if (rsp_valid) rsp_c = c;
            @(posedge clk); #1;
        end
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL attr_ready: got %0d, required 1", rdy0); end
        tests++; if ({reg_c1, a_c1} !== {1'b0, 15'h0100}) begin fails++;
            $display("FAIL attr_setup: got reg_n=%0d addr=%04h, required reg_n=0 addr=0100", reg_c1, a_c1); end
        tests++; if (first_oe != 3 || last_oe != 12 || n_oe != 10) begin fails++;
            $display("FAIL attr_oe_window: got %0d..%0d (%0d), required 3..12 (10)", first_oe, last_oe, n_oe); end
        tests++; if (rsp_c != 15) begin fails++; $display("FAIL attr_rsp_cycle: got %0d, required 15", rsp_c); end
        tests++; if ({busy_c1, busy_c16} !== 2'b10) begin fails++;
            $display("FAIL attr_busy: got c1=%0d c16=%0d, required c1=1 c16=0", busy_c1, busy_c16); end
    endtask

    task automatic test_round_robin();
        int g0[$], g1[$];
        logic reg_c1, reg_c17;
        do_reset();
        ci_d_in = 8'hA5;
        req0_valid = 1'b1; req0_space = SPACE_COMMON; req0_write = 1'b0; req0_addr = 15'h1234;
        req1_valid = 1'b1; req1_space = SPACE_ATTR;   req1_write = 1'b0; req1_addr = 15'h0002;
        sb.push_back('{1'b0, 8'hA5, 1'b0});
        sb.push_back('{1'b1, 8'hA5, 1'b0});
        sb.push_back('{1'b0, 8'hA5, 1'b0});
        for (int c = 0; c < 50; c++) begin
            if (g0.size() >= 2) req0_valid = 1'b0;
            if (g1.size() >= 1) req1_valid = 1'b0;
            @(negedge clk);
            if (req0_ready) g0.push_back(c);
            if (req1_ready) g1.push_back(c);
            if (c == 1)  reg_c1  = ci_reg_n;
            if (c == 17) reg_c17 = ci_reg_n;
            @(posedge clk); #1;
        end
        tests++; if (g0.size() != 2 || g0[0] != 0 || g0[1] != 32) begin fails++;
            $display("FAIL rr_port0_grants: got n=%0d first=%0d second=%0d, required n=2 at 0 and 32",
                     g0.size(), (g0.size() > 0) ? g0[0] : -1, (g0.size() > 1) ? g0[1] : -1); end
        tests++; if (g1.size() != 1 || g1[0] != 16) begin fails++;
            $display("FAIL rr_port1_grant: got n=%0d first=%0d, required n=1 at 16",
                     g1.size(), (g1.size() > 0) ? g1[0] : -1); end
        tests++; if ({reg_c1, reg_c17} !== 2'b10) begin fails++;
            $display("FAIL rr_reg_n: got common=%0d attr=%0d, required common=1 attr=0", reg_c1, reg_c17); end
    endtask

    task automatic test_io_write();
        int first_wr = -1, n_wr = 0, other = 0, oe_first = -1, oe_last = -1, bad_d = 0, rsp_c = -1;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_space = SPACE_IO; req1_write = 1'b1; req1_addr = 15'h0001; req1_wdata = 8'h3C;
        sb.push_back('{1'b1, 8'h00, 1'b0});
        for (int c = 0; c < 20; c++) begin
            if (c == 1) req1_valid = 1'b0;
            @(negedge clk);
            if (!ci_iowr_n) begin if (first_wr < 0) first_wr = c; n_wr++; end
            if (!ci_oe_n || !ci_we_n || !ci_iord_n) other++;
            if (ci_d_oe) begin
                if (oe_first < 0) oe_first = c;
                oe_last = c;
                if (ci_d_out !== 8'h3C) bad_d++;
            end
            if (rsp_valid) rsp_c = c;
            @(posedge clk); #1;
        end
        tests++; if (first_wr != 3 || n_wr != 10 || other != 0) begin fails++;
            $display("FAIL iowr_strobe: got first=%0d n=%0d other=%0d, required first=3 n=10 other=0",
                     first_wr, n_wr, other); end
        tests++; if (oe_first != 1 || oe_last != 14 || bad_d != 0) begin fails++;
            $display("FAIL iowr_data: got oe %0d..%0d bad=%0d, required oe 1..14 bad=0", oe_first, oe_last, bad_d); end
        tests++; if (rsp_c != 15) begin fails++; $display("FAIL iowr_rsp_cycle: got %0d, required 15", rsp_c); end
    endtask

    task automatic test_io_read();
        for (int k = 0; k < 2; k++) begin
            int n_rd = 0, rsp_c = -1;
            @(posedge clk); #1;
            ci_d_in     = 8'h77;
            ci_inpack_n = (k == 0);
            req0_valid = 1'b1; req0_space = SPACE_IO; req0_write = 1'b0; req0_addr = 15'h0010;
            if (k == 0) sb.push_back('{1'b0, 8'h00, 1'b1});
            else        sb.push_back('{1'b0, 8'h77, 1'b0});
            for (int c = 0; c < 17; c++) begin
                if (c == 1) req0_valid = 1'b0;
                @(negedge clk);
                if (!ci_iord_n) n_rd++;
                if (rsp_valid) rsp_c = c;
                @(posedge clk); #1;
            end
            tests++; if (n_rd != 10 || rsp_c != 15) begin fails++;
                $display("FAIL iord_%0d: got strobe=%0d rsp=%0d, required strobe=10 rsp=15", k, n_rd, rsp_c); end
        end
        ci_inpack_n = 1'b1;
    endtask

    task automatic test_err_path();
        int rc[$];
        int active = 0;
        logic rdy0_c0, rdy1_c2;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_space = SPACE_RSVD; req0_write = 1'b0; req0_addr = 15'h0003;
        sb.push_back('{1'b0, 8'h00, 1'b1});
        sb.push_back('{1'b1, 8'h00, 1'b1});
        for (int c = 0; c < 8; c++) begin
            if (c == 1) req0_valid = 1'b0;
            if (c == 2) begin
                cam_present = 1'b0;
                req1_valid = 1'b1; req1_space = SPACE_COMMON; req1_write = 1'b1; req1_addr = 15'h0040;
            end
            if (c == 3) req1_valid = 1'b0;
            @(negedge clk);
            if (c == 0) rdy0_c0 = req0_ready;
            if (c == 2) rdy1_c2 = req1_ready;
            if (bus_vec !== BUS_IDLE) active++;
            if (rsp_valid) rc.push_back(c);
            @(posedge clk); #1;
        end
        cam_present = 1'b1;
        tests++; if ({rdy0_c0, rdy1_c2} !== 2'b11) begin fails++;
            $display("FAIL err_grants: got c0=%0d c2=%0d, required both 1", rdy0_c0, rdy1_c2); end
        tests++; if (rc.size() != 2 || rc[0] != 1 || rc[1] != 3) begin fails++;
            $display("FAIL err_rsp_cycles: got n=%0d first=%0d, required rsp at 1 and 3",
                     rc.size(), (rc.size() > 0) ? rc[0] : -1); end
        tests++; if (active != 0) begin fails++;
            $display("FAIL err_bus_quiet: got %0d active cycles, required 0", active); end
    endtask

    task automatic test_reset_mid();
        int n_rsp = 0, rsp_c = -1;
        logic [30:0] bus_c8;
        logic        busy_c8, we_c7, rdy0, rdy1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_space = SPACE_COMMON; req0_write = 1'b1; req0_addr = 15'h7FFF; req0_wdata = 8'h81;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) req0_valid = 1'b0;
            if (c == 7) rst = 1'b1;
            if (c == 8) rst = 1'b0;
            @(negedge clk);
            if (c == 7) we_c7 = ci_we_n;
            if (c == 8) begin bus_c8 = bus_vec; busy_c8 = busy; end
            if (rsp_valid) n_rsp++;
            @(posedge clk); #1;
        end
        tests++; if (we_c7 !== 1'b0) begin fails++; $display("FAIL rstmid_in_strobe: got we_n=%0d, required 0", we_c7); end
        tests++; if ({bus_c8, busy_c8} !== {BUS_IDLE, 1'b0}) begin fails++;
            $display("FAIL rstmid_idle: got bus=%08h busy=%0d, required bus=%08h busy=0", bus_c8, busy_c8, BUS_IDLE); end
        tests++; if (n_rsp != 0) begin fails++; $display("FAIL rstmid_no_rsp: got %0d responses, required 0", n_rsp); end

        ci_d_in = 8'hA5;
        req0_valid = 1'b1; req0_space = SPACE_ATTR; req0_write = 1'b0; req0_addr = 15'h0000;
        req1_valid = 1'b1; req1_space = SPACE_ATTR; req1_write = 1'b0; req1_addr = 15'h0008;
        sb.push_back('{1'b0, 8'hA5, 1'b0});
        for (int c = 0; c < 17; c++) begin
            if (c == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
            if (c == 0) begin rdy0 = req0_ready; rdy1 = req1_ready; end
            if (rsp_valid) rsp_c = c;
            @(posedge clk); #1;
        end
        tests++; if ({rdy0, rdy1} !== 2'b10 || rsp_c != 15) begin fails++;
            $display("FAIL rstmid_regrant: got ready0=%0d ready1=%0d rsp=%0d, required ready0=1 ready1=0 rsp=15",
                     rdy0, rdy1, rsp_c); end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_space = SPACE_ATTR; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_space = SPACE_ATTR; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        cam_present = 1'b1;
        ci_d_in     = 8'h00;
        ci_inpack_n = 1'b1;

        test_reset();
        test_attr_read();
        test_round_robin();
        test_io_write();
        test_io_read();
        test_err_path();
        test_reset_mid();

        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (sb.size() != 0) begin fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
        tests++; if (viol != 0) begin fails++;
            $display("FAIL strobe_rules: got %0d violations, required 0", viol); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
